dram_cmd_scheduler: RTL and testbench
=====================================

DRAM_CMD_SCHEDULER -- requirements
Module: dram_cmd_scheduler

Interface
REQ-001 SHALL have parameter T_RCD, default 24, minimum clk cycles from an ACT issue edge to a RD/WR issue edge.
REQ-002 SHALL have parameter T_RP, default 24, minimum cycles from a PRE issue edge to the next ACT issue edge.
REQ-003 SHALL have parameter T_RAS, default 52, minimum cycles from an ACT to a PRE on the same bank.
REQ-004 SHALL have parameter T_CCD, default 8, minimum cycles between any two RD/WR issue edges.
REQ-005 SHALL have parameter T_RTP, default 12, minimum cycles from a RD to a PRE on the same bank.
REQ-006 SHALL have parameter T_WTP, default 44, minimum cycles from a WR to a PRE on the same bank.
REQ-007 SHALL have port clk, input, 1, the only clock; all state changes on posedge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port req_valid, input, 1, the queue presents a request.
REQ-010 SHALL have port req_opcode, input, 2, 0=READ, 1=WRITE, 2=IFETCH; 3 is illegal.
REQ-011 SHALL have port req_address, input, 33, CPU address, decoded with the global_defs masks/offsets.
REQ-012 SHALL have port req_ready, output, 1, scheduler accepts a request this cycle.
REQ-013 SHALL have port cmd, output, 3, 0=NOP, 1=ACT, 2=RD, 3=WR, 4=PRE.
REQ-014 SHALL have ports cmd_bg (2), cmd_ba (2), cmd_row (15), cmd_col (10), outputs, fields of the latched request.
REQ-015 SHALL have port req_done, output, 1, one-cycle pulse coincident with the RD/WR command.

Function
REQ-016 SHALL use states IDLE, PRE, ACT, CAS. req_ready = 1 only in IDLE.
REQ-017 SHALL accept a request on a posedge with req_valid && req_ready, then latch opcode and decoded bg/ba/row/col.
REQ-018 SHALL, on accept, use the per-bank open-row table (16 entries: valid bit plus 15-bit row) to pick the next state:
  - bank open, row equal: CAS
  - bank open, row different: PRE
  - bank closed: ACT
REQ-019 SHALL, in PRE/ACT/CAS, issue the command on the first posedge at which every timing constraint for it is met, then move:
  - PRE -> ACT
  - ACT -> CAS
  - CAS -> IDLE
REQ-020 SHALL register cmd and hold it for exactly one cycle after the issue edge; cmd = NOP at all other times.
REQ-021 SHALL issue RD for READ and IFETCH, and WR for WRITE. An illegal opcode SHALL be accepted and dropped with no command and no req_done.
REQ-022 SHALL update the open-row table on each issue: ACT sets valid and row; PRE clears valid. The policy is open-page; no auto-precharge.
REQ-023 SHALL keep per-bank precharge-block down-counters, each saturating at 0:
  - ACT loads T_RAS
  - RD loads max(current, T_RTP)
  - WR loads max(current, T_WTP)
REQ-024 SHALL keep global counters since the last ACT (gates CAS by T_RCD), PRE (gates ACT by T_RP) and CAS (gates CAS by T_CCD). These SHALL saturate and never wrap.
REQ-025 SHALL impose earliest-issue edge = state-entry edge + 1 when no constraint blocks. A closed-bank request accepted at edge E0 issues ACT at E0+1 and RD/WR at E0+1+T_RCD.
REQ-026 SHALL ignore req_valid outside IDLE. The next accept is no earlier than the edge after CAS issue.
REQ-027 SHALL hold cmd_bg/ba/row/col at the latched values until the next accept.

Reset
REQ-028 SHALL, on rst_n low at any time including mid-sequence, immediately force:
  - state IDLE
  - cmd NOP
  - req_done 0
  - all field outputs 0
  - all banks closed
  - all counters 0 (no timing blocks)
REQ-029 SHALL assert req_ready = 1 on the first cycle after rst_n deasserts.

Verification
REQ-030 SHALL cover a closed-bank READ: after reset, READ bg1 ba2 row 0x0010 accepted at E0 -> ACT at E0+1, RD at E0+25 with req_done, cmd NOP elsewhere.
REQ-031 SHALL cover a row hit: READ to the same row offered right after the REQ-030 RD -> no ACT/PRE; RD exactly 8 cycles after the previous RD.
REQ-032 SHALL cover a row miss: READ row 0x0020 on the same bank right after REQ-030 -> PRE at max(ACT+52, RD+12), ACT 24 later, RD 24 after that.
REQ-033 SHALL cover write recovery: WRITE hit, then READ miss on the same bank -> WR issued; PRE no earlier than WR+44.
REQ-034 SHALL cover opcodes: IFETCH produces RD. Opcode 3 is accepted and produces no command and no req_done; req_ready returns the next cycle.
REQ-035 SHALL cover reset mid-sequence: rst_n pulsed between ACT and RD -> no RD issued; the same request replayed issues ACT again (bank closed).

Source files
------------

// File: rtl/dram_cmd_scheduler_if.sv
// Request queue to scheduler handshake plus the issued DRAM command bus.
interface dram_cmd_scheduler_if;
    logic        req_valid;
    logic [1:0]  req_opcode;
    logic [32:0] req_address;
    logic        req_ready;
    logic [2:0]  cmd;
    logic [1:0]  cmd_bg;
    logic [1:0]  cmd_ba;
    logic [14:0] cmd_row;
    logic [9:0]  cmd_col;
    logic        req_done;

    // Request source / command consumer side
    modport master (
        output req_valid, req_opcode, req_address,
        input  req_ready, cmd, cmd_bg, cmd_ba, cmd_row, cmd_col, req_done
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_opcode, req_address,
        output req_ready, cmd, cmd_bg, cmd_ba, cmd_row, cmd_col, req_done
    );
endinterface

// File: rtl/dram_cmd_scheduler.sv
// Single-request DRAM command scheduler: open-page policy, per-bank open-row
// table, timing gates for tRCD/tRP/tRAS/tCCD/tRTP/tWTP.
// Address map: [2:0] byte offset, [12:3] col, [14:13] bg, [16:15] ba,
// [31:17] row, [32] unused.
module dram_cmd_scheduler #(
    parameter int T_RCD = 24,
    parameter int T_RP  = 24,
    parameter int T_RAS = 52,
    parameter int T_CCD = 8,
    parameter int T_RTP = 12,
    parameter int T_WTP = 44
) (
    input logic clk,
    input logic rst_n,
    dram_cmd_scheduler_if.slave bus
);
    localparam int CW = 16;
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] RCD_C = CW'(T_RCD);
    localparam logic [CW-1:0] RP_C  = CW'(T_RP);
    localparam logic [CW-1:0] RAS_C = CW'(T_RAS);
    localparam logic [CW-1:0] CCD_C = CW'(T_CCD);
    localparam logic [CW-1:0] RTP_C = CW'(T_RTP);
    localparam logic [CW-1:0] WTP_C = CW'(T_WTP);
    localparam logic [1:0] OP_WRITE   = 2'd1;
    localparam logic [1:0] OP_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {IDLE, PRE, ACT, CAS} state_t;
    typedef enum logic [2:0] {CMD_NOP = 3'd0, CMD_ACT = 3'd1, CMD_RD = 3'd2,
                              CMD_WR = 3'd3, CMD_PRE = 3'd4} cmd_t;

    state_t state, state_nxt;
    cmd_t   cmd_q;
    logic   done_q;
    logic   issue_pre, issue_act, issue_cas;

    logic [1:0]  dec_bg, dec_ba, lat_bg, lat_ba, lat_op;
    logic [14:0] dec_row, lat_row;
    logic [9:0]  dec_col, lat_col;
    logic [3:0]  dec_bank, lat_bank;
    logic        unused_addr_bits;

    logic [15:0]   open_vld;
    logic [14:0]   open_row [16];
    // Timing counters hold remaining wait; a command is legal once <= 1,
    // so a value T loaded at edge E releases the command at edge E+T.
    logic [CW-1:0] bank_cnt [16];
    logic [CW-1:0] rcd_cnt, rp_cnt, ccd_cnt;
    logic [CW-1:0] bank_dec, recover;

    assign dec_col  = bus.req_address[12:3];
    assign dec_bg   = bus.req_address[14:13];
    assign dec_ba   = bus.req_address[16:15];
    assign dec_row  = bus.req_address[31:17];
    assign dec_bank = {dec_bg, dec_ba};
    assign lat_bank = {lat_bg, lat_ba};
    assign unused_addr_bits = ^{bus.req_address[32], bus.req_address[2:0]};

    assign bus.cmd      = cmd_q;
    assign bus.req_done = done_q;
    assign bus.cmd_bg   = lat_bg;
    assign bus.cmd_ba   = lat_ba;
    assign bus.cmd_row  = lat_row;
    assign bus.cmd_col  = lat_col;

    function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v);
        return (v == '0) ? v : v - ONE;
    endfunction

    assign bank_dec = sat_dec(bank_cnt[lat_bank]);
    assign recover  = (lat_op == OP_WRITE) ? WTP_C : RTP_C;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state, ready and command-issue decisions
    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        issue_pre     = 1'b0;
        issue_act     = 1'b0;
        issue_cas     = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (bus.req_opcode == OP_ILLEGAL)  state_nxt = IDLE;
                    else if (open_vld[dec_bank] && open_row[dec_bank] == dec_row)
                                                       state_nxt = CAS;
                    else if (open_vld[dec_bank])       state_nxt = PRE;
                    else                               state_nxt = ACT;
                end
            end
            PRE: if (bank_cnt[lat_bank] <= ONE) begin
                issue_pre = 1'b1;
                state_nxt = ACT;
            end
            ACT: if (rp_cnt <= ONE) begin
                issue_act = 1'b1;
                state_nxt = CAS;
            end
            CAS: if (rcd_cnt <= ONE && ccd_cnt <= ONE) begin
                issue_cas = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, command register, open-row table and timing counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q    <= CMD_NOP;
            done_q   <= 1'b0;
            lat_op   <= '0;
            lat_bg   <= '0;
            lat_ba   <= '0;
            lat_row  <= '0;
            lat_col  <= '0;
            open_vld <= '0;
            rcd_cnt  <= '0;
            rp_cnt   <= '0;
            ccd_cnt  <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                open_row[i] <= '0;
                bank_cnt[i] <= '0;
            end
        end else begin
            cmd_q   <= CMD_NOP;
            done_q  <= 1'b0;
            rcd_cnt <= sat_dec(rcd_cnt);
            rp_cnt  <= sat_dec(rp_cnt);
            ccd_cnt <= sat_dec(ccd_cnt);
            for (int unsigned i = 0; i < 16; i++)
                bank_cnt[i] <= sat_dec(bank_cnt[i]);
            if (state == IDLE && bus.req_valid) begin
                lat_op  <= bus.req_opcode;
                lat_bg  <= dec_bg;
                lat_ba  <= dec_ba;
                lat_row <= dec_row;
                lat_col <= dec_col;
            end
            if (issue_pre) begin
                cmd_q              <= CMD_PRE;
                open_vld[lat_bank] <= 1'b0;
                rp_cnt             <= RP_C;
            end
            if (issue_act) begin
                cmd_q              <= CMD_ACT;
                open_vld[lat_bank] <= 1'b1;
                open_row[lat_bank] <= lat_row;
                rcd_cnt            <= RCD_C;
                bank_cnt[lat_bank] <= RAS_C;
            end
            if (issue_cas) begin
                cmd_q              <= (lat_op == OP_WRITE) ? CMD_WR : CMD_RD;
                done_q             <= 1'b1;
                ccd_cnt            <= CCD_C;
                bank_cnt[lat_bank] <= (bank_dec > recover) ? bank_dec : recover;
            end
        end
    end
endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Self-checking bench: randomized and directed requests checked every cycle
// against a transaction-level timing model of the scheduler.
module tb_dram_cmd_scheduler;
    localparam int T_RCD = 24, T_RP = 24, T_RAS = 52, T_CCD = 8, T_RTP = 12, T_WTP = 44;
    localparam int NEG = -100000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dram_cmd_scheduler_if bus();

    dram_cmd_scheduler #(
        .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS),
        .T_CCD(T_CCD), .T_RTP(T_RTP), .T_WTP(T_WTP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model (issue-edge arithmetic) ----------------
    typedef struct { int edge_no; int cmd; } ev_t;
    ev_t evq[$];
    int  e = 0;
    bit  m_open [16];
    int  m_row [16];
    int  m_pre_ok [16];
    int  m_last_act, m_last_pre, m_last_cas, m_free;
    int  m_bg, m_ba, m_rowl, m_col;
    int  obs_act, obs_pre, obs_cas, obs_cas_cmd, obs_acc;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [32:0] mk(input int bg, input int ba, input int row, input int col);
        longint v;
        v = longint'(row) * 131072 + longint'(ba) * 32768 + longint'(bg) * 8192 + longint'(col) * 8;
        return v[32:0];
    endfunction

    task automatic model_reset();
        evq.delete();
        for (int i = 0; i < 16; i++) begin
            m_open[i] = 0; m_row[i] = 0; m_pre_ok[i] = NEG;
        end
        m_last_act = NEG; m_last_pre = NEG; m_last_cas = NEG; m_free = 0;
        m_bg = 0; m_ba = 0; m_rowl = 0; m_col = 0;
    endtask

    task automatic push(input int t, input int c);
        ev_t ev;
        ev.edge_no = t; ev.cmd = c;
        evq.push_back(ev);
    endtask

    task automatic model_accept(input int acc_edge, input int op, input logic [32:0] a);
        longint la;
        int b, t;
        la     = longint'(a);
        m_col  = int'((la / 8) % 1024);
        m_bg   = int'((la / 8192) % 4);
        m_ba   = int'((la / 32768) % 4);
        m_rowl = int'((la / 131072) % 32768);
        obs_acc = acc_edge;
        if (op == 3) begin
            m_free = acc_edge + 1;
            return;
        end
        b = m_bg * 4 + m_ba;
        t = acc_edge;
        if (!(m_open[b] && m_row[b] == m_rowl)) begin
            if (m_open[b]) begin
                t = imax(t + 1, m_pre_ok[b]);
                push(t, 4);
                m_last_pre = t;
                m_open[b] = 0;
            end
            t = imax(t + 1, m_last_pre + T_RP);
            push(t, 1);
            m_last_act = t;
            m_open[b] = 1;
            m_row[b] = m_rowl;
            m_pre_ok[b] = t + T_RAS;
        end
        t = imax(imax(t + 1, m_last_act + T_RCD), m_last_cas + T_CCD);
        push(t, (op == 1) ? 3 : 2);
        m_last_cas = t;
        m_pre_ok[b] = imax(m_pre_ok[b], t + ((op == 1) ? T_WTP : T_RTP));
        m_free = t + 1;
    endtask

    // ---------------- one clock cycle: drive, predict, observe ----------------
    task automatic cycle(input bit v, input int op, input logic [32:0] a, output bit acc);
        bit exp_rdy;
        int exp_cmd;
        bus.req_valid   = v;
        bus.req_opcode  = op[1:0];
        bus.req_address = a;
        exp_rdy = (e + 1 >= m_free);
        check("req_ready", bus.req_ready, exp_rdy);
        acc = v && exp_rdy && (rst_n === 1'b1);
        if (acc) model_accept(e + 1, op, a);
        @(posedge clk);
        e++;
        @(negedge clk);
        exp_cmd = 0;
        if (evq.size() > 0 && evq[0].edge_no == e) begin
            exp_cmd = evq[0].cmd;
            void'(evq.pop_front());
        end
        check("cmd", bus.cmd, exp_cmd);
        check("req_done", bus.req_done, (exp_cmd == 2 || exp_cmd == 3));
        check("fields", {bus.cmd_bg, bus.cmd_ba, bus.cmd_row, bus.cmd_col},
              {m_bg[1:0], m_ba[1:0], m_rowl[14:0], m_col[9:0]});
        case (bus.cmd)
            3'd1: obs_act = e;
            3'd2, 3'd3: begin obs_cas = e; obs_cas_cmd = int'(bus.cmd); end
            3'd4: obs_pre = e;
            default: ;
        endcase
    endtask

    task automatic send(input int op, input logic [32:0] a);
        bit acc;
        int n;
        n = 0;
        acc = 0;
        while (!acc && n < 300) begin
            cycle(1'b1, op, a, acc);
            n++;
        end
        check("accept_in_time", acc, 1'b1);
    endtask

    task automatic idle(input int cycles);
        bit acc;
        for (int i = 0; i < cycles; i++) cycle(1'b0, 0, '0, acc);
    endtask

    task automatic wait_idle();
        bit acc;
        int n;
        n = 0;
        while ((evq.size() > 0 || e + 1 < m_free) && n < 400) begin
            cycle(1'b0, 0, '0, acc);
            n++;
        end
        check("idle_in_time", (n < 400), 1'b1);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_cmd", bus.cmd, 3'd0);
        check("rst_done", bus.req_done, 1'b0);
        check("rst_fields", {bus.cmd_bg, bus.cmd_ba, bus.cmd_row, bus.cmd_col}, '0);
        model_reset();
        idle(2);
        rst_n = 1'b1;
    endtask

    int e0, act0, rd0, wr0, pre1, rst_edge, n;
    bit acc;

    initial begin
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_opcode = '0;
        bus.req_address = '0;
        obs_act = NEG; obs_pre = NEG; obs_cas = NEG; obs_cas_cmd = 0; obs_acc = NEG;
        model_reset();
        @(negedge clk);
        do_reset();

        // Closed-bank READ: ACT one edge after accept, RD tRCD later
        send(0, mk(1, 2, 16, 5));
        e0 = obs_acc;
        wait_idle();
        act0 = obs_act;
        rd0  = obs_cas;
        check("closed_act_edge", act0 - e0, 1);
        check("closed_rd_edge", rd0 - e0, 25);

        // Row hit immediately after: RD exactly tCCD after previous RD
        send(0, mk(1, 2, 16, 9));
        wait_idle();
        check("hit_ccd", obs_cas - rd0, T_CCD);
        check("hit_no_act", obs_act, act0);
        rd0 = obs_cas;

        // Row miss: PRE gated by tRAS from ACT, then tRP, then tRCD
        send(0, mk(1, 2, 32, 1));
        wait_idle();
        check("miss_pre", obs_pre - act0, T_RAS);
        check("miss_act", obs_act - obs_pre, T_RP);
        check("miss_rd", obs_cas - obs_act, T_RCD);

        // Write recovery: WR hit, then miss must wait tWTP from WR
        send(1, mk(1, 2, 32, 2));
        send(0, mk(1, 2, 16, 3));
        wr0 = obs_cas;
        check("wr_cmd", obs_cas_cmd, 3);
        wait_idle();
        check("wtp_pre", obs_pre - wr0, T_WTP);

        // IFETCH issues RD; illegal opcode is accepted and dropped
        send(2, mk(1, 2, 16, 4));
        wait_idle();
        check("ifetch_rd", obs_cas_cmd, 2);
        rd0 = obs_cas;
        send(3, mk(2, 1, 5, 6));
        check("illegal_ready", bus.req_ready, 1'b1);
        idle(3);
        check("illegal_no_cas", obs_cas, rd0);

        // Reset between ACT and RD; replay reopens the bank with ACT
        send(0, mk(0, 0, 7, 0));
        e0 = obs_acc;
        n = 0;
        while (obs_act < e0 && n < 50) begin
            cycle(1'b0, 0, '0, acc);
            n++;
        end
        check("rst_seq_act_seen", obs_act - e0, 1);
        idle(4);
        rst_edge = e;
        do_reset();
        idle(30);
        check("rst_no_rd", (obs_cas < rst_edge), 1'b1);
        send(0, mk(0, 0, 7, 0));
        e0 = obs_acc;
        wait_idle();
        check("replay_act", obs_act - e0, 1);
        check("replay_rd", obs_cas - e0, 25);

        // Randomized traffic over a few banks and rows
        for (int k = 0; k < 80; k++) begin
            send(int'($urandom_range(0, 3)),
                 mk(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 1023))));
            idle(int'($urandom_range(0, 3)));
        end
        wait_idle();
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
